sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle unsigned restoring divider, the inverse of the team's shift-add sequential multiplier. It produces one quotient bit per clock. Operands are captured on a start handshake, and the quotient and remainder are held stable with `done` asserted until the next operation starts. It sits beside the multiplier in the arithmetic unit and uses the same start/done control style.

## Interface
- `WIDTH`, default 8: dividend, divisor, quotient and remainder width in bits (legal range 2–32).
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted); takes effect immediately, independent of `clk`.
- `start` in 1: request; sampled only in IDLE or FIN.
- `dividend` in WIDTH: unsigned numerator; sampled on the edge that accepts `start`.
- `divisor` in WIDTH: unsigned denominator; sampled on the same edge.
- `quotient` out WIDTH: registered result; valid while `done`=1.
- `remainder` out WIDTH: registered result; valid while `done`=1.
- `done` out 1: level; 1 in FIN only.
- `busy` out 1: 1 in CALC only.
- `div_by_zero` out 1: 1 in FIN when the accepted divisor was 0 (see Configuration).

## Operation
- **States:** IDLE, CALC, FIN.
- **Accept:** in IDLE or FIN with `start`=1 on an edge:
  - latch `dividend` into the quotient shift register;
  - latch `divisor`;
  - clear the partial remainder (WIDTH+1 bits);
  - set counter to WIDTH;
  - clear `done` and `div_by_zero`;
  - go to CALC.
- **CALC, each edge:**
  - shift {rem, quo} left 1; the quotient MSB enters the remainder LSB;
  - compute trial = rem − divisor at WIDTH+1 bits;
  - if trial ≥ 0: rem = trial, quotient LSB = 1; else restore, quotient LSB = 0;
  - decrement the counter.
  - When the counter reaches 0 on an edge, that same edge registers `quotient`/`remainder`, sets `done`=1 and goes to FIN.
- **FIN:** outputs hold. `start`=0 stays in FIN. `start`=1 is a new accept (back-to-back allowed, with no IDLE visit).
- **CALC ignores `start`.** Operand input changes after accept have no effect.
- **Remainder width:** always < divisor, so it fits in WIDTH bits. The top bit of the internal remainder is the borrow guard only.

## Timing
- **Reset values:** state IDLE; `quotient`, `remainder` = 0; `done`, `busy`, `div_by_zero` = 0; counter 0.
- **Latency:** accept at edge N gives `busy`=1 after N. `done`=1 and results valid after edge N+WIDTH (8 edges for WIDTH=8). Throughput is one result per WIDTH+1 edges with `start` held high.
- **Reset mid-CALC:** aborts immediately, all outputs return to reset values, and no partial result is exposed.
- **Reset released while `start`=1:** the first edge after release accepts.
- **`done` and `busy` are never both 1.**

## Configuration
- `DIV_BY_ZERO_CHECK_EN` **defined:** an accept with divisor = 0 goes directly to FIN on the next edge (1-edge latency). It registers `quotient` = all ones, `remainder` = dividend, `div_by_zero`=1 and `busy`=0.
- `DIV_BY_ZERO_CHECK_EN` **undefined:** divisor 0 runs the full WIDTH iterations. The algorithm naturally yields all ones and remainder = dividend, and `div_by_zero` is tied to 0.

## Structure
- **Package `div_pkg`:**
  - state enum (IDLE, CALC, FIN);
  - default width constant `DIV_WIDTH_DEFAULT` = 8;
  - counter width function clog2(WIDTH+1).
- **Sub-module `div_step`:** combinational, one restoring iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo. The top level holds the FSM, counter and registers.

## Test plan
- Reset low then high, idle 3 cycles → all outputs 0, state IDLE, `done`=0.
- `start` with 100/7 (WIDTH=8) → `busy` for 8 edges, then `done`=1, quotient 14, remainder 2, held until the next start.
- 255/1, then back-to-back 5/9 with `start` held in FIN → 255 r0; then `done` drops for 8 edges and gives 0 r5.
- 37/0 → with macro: `done` after 1 edge, quotient 255, remainder 37, `div_by_zero`=1. Without macro: after 8 edges, 255 r37, flag 0.
- Start 200/13, assert `reset` low at CALC edge 4 → outputs immediately 0, `busy` 0. Release, restart 200/13 → 15 r5.
- Change `dividend`/`divisor` and pulse `start` during CALC of 100/7 → ignored; result still 14 r2.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg
//   Shared types and constants for the sequential restoring divider.
//   - div_state_t       : controller states (IDLE, CALC, FIN)
//   - DIV_WIDTH_DEFAULT : default operand width
//   - cnt_width()       : width of the iteration counter, clog2(WIDTH+1),
//                         so the counter can hold the value WIDTH itself
`timescale 1ns/1ps
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division iteration.
//   Ports:
//     rem      in  WIDTH : current partial remainder (always < divisor)
//     quo      in  WIDTH : quotient shift register; its MSB feeds the remainder
//     divisor  in  WIDTH : unsigned denominator
//     rem_nxt  out WIDTH : partial remainder after this iteration
//     quo_nxt  out WIDTH : quotient register after this iteration (new bit in LSB)
`timescale 1ns/1ps
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  // The shifted remainder needs WIDTH+1 bits; its extra bit plus the sign of
  // the trial difference act as the borrow guard. Because rem < divisor on
  // entry, whichever value is kept always fits back into WIDTH bits.
  logic        [WIDTH:0] shifted;
  logic signed [WIDTH:0] trial;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = $signed(shifted - {1'b0, divisor});
    if (trial >= 0) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// sequential_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Operands are captured when start is accepted in IDLE or FIN; the result
//   is held with done=1 until the next accept. start is ignored in CALC.
//   Optional feature macro: DIV_BY_ZERO_CHECK_EN
//     defined   : divisor 0 finishes on the accepting edge with
//                 quotient=all ones, remainder=dividend, div_by_zero=1
//     undefined : divisor 0 runs all WIDTH iterations (the algorithm yields
//                 the same values) and div_by_zero is tied to 0
//   Ports:
//     clk          in  1     : clock, rising edge
//     reset        in  1     : asynchronous, active-low
//     start        in  1     : operation request (sampled in IDLE/FIN)
//     dividend     in  WIDTH : unsigned numerator
//     divisor      in  WIDTH : unsigned denominator
//     quotient     out WIDTH : registered result, valid while done
//     remainder    out WIDTH : registered result, valid while done
//     done         out 1     : 1 in FIN only
//     busy         out 1     : 1 in CALC only
//     div_by_zero  out 1     : accepted divisor was 0 (feature build only)
`timescale 1ns/1ps
module sequential_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;

  // Working datapath registers; they carry no reset because nothing observes
  // them outside CALC and every accept reloads them.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  logic accept;
  logic last;
  logic zero_div;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dsr_q),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  assign accept = ((state == IDLE) || (state == FIN)) && start;
  // The counter is about to reach 0 on this edge: final iteration.
  assign last   = (state == CALC) && (cnt == CNT_W'(1));

`ifdef DIV_BY_ZERO_CHECK_EN
  assign zero_div = accept && (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign done = (state == FIN);
  assign busy = (state == CALC);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FIN: begin
        if (accept) state_nxt = zero_div ? FIN : CALC;
      end
      CALC: begin
        if (last) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;

      if (accept) cnt <= zero_div ? '0 : CNT_W'(WIDTH);
      else if (state == CALC) cnt <= cnt - CNT_W'(1);

      if (zero_div) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (last) begin
        quotient  <= quo_step;
        remainder <= rem_step;
      end
    end
  end

`ifdef DIV_BY_ZERO_CHECK_EN
  logic dbz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dbz_q <= 1'b0;
    else if (accept) dbz_q <= zero_div;
  end

  assign div_by_zero = dbz_q && (state == FIN);
`else
  assign div_by_zero = 1'b0;
`endif

  // Datapath: load on accept, one restoring step per CALC edge
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (state == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
`timescale 1ns/1ps
module tb_sequential_divider;

  localparam int W = 8;
`ifdef DIV_BY_ZERO_CHECK_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; edges counted from the accepting edge.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned q, output int unsigned r,
                                output bit dz, output int lat);
    if (b == 0) begin
      q   = (1 << W) - 1;
      r   = a;
      dz  = DBZ_EN;
      lat = DBZ_EN ? 1 : W + 1;
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 1'b0;
      lat = W + 1;
    end
  endfunction

  task automatic launch(input int unsigned a, input int unsigned b);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
  endtask

  task automatic wait_done(input bit drop, input int e0, output int edges, output bit overlap);
    edges   = e0;
    overlap = 1'b0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (drop) start = 1'b0;
      if (done && busy) overlap = 1'b1;
    end while (!done && edges < 4 * W);
  endtask

  task automatic finish_op(input string tag, input int unsigned a, input int unsigned b,
                           input int edges, input bit overlap);
    int unsigned q, r;
    bit dz;
    int lat;
    model(a, b, q, r, dz, lat);
    check($sformatf("%s_lat", tag), edges, lat);
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_q", tag), quotient, q);
    check($sformatf("%s_r", tag), remainder, r);
    check($sformatf("%s_dbz", tag), div_by_zero, dz);
    check($sformatf("%s_excl", tag), overlap, 0);
  endtask

  task automatic run_op(input string tag, input int unsigned a, input int unsigned b);
    int edges;
    bit ov;
    launch(a, b);
    wait_done(1'b1, 0, edges, ov);
    finish_op(tag, a, b, edges, ov);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    bit ov;
    int unsigned a, b;

    // Reset is asynchronous: outputs are 0 before any clock edge.
    #2;
    check("rst_async_q", quotient, 0);
    check("rst_async_r", remainder, 0);
    check("rst_async_done", done, 0);
    check("rst_async_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_q", quotient, 0);
    check("idle_r", remainder, 0);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_dbz", div_by_zero, 0);

    // Basic operation and hold in FIN with start low.
    run_op("d100_7", 100, 7);
    repeat (3) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_q", quotient, 14);
    check("hold_r", remainder, 2);

    // Back-to-back with start held high through FIN.
    launch(255, 1);
    wait_done(1'b0, 0, edges, ov);
    finish_op("d255_1", 255, 1, edges, ov);
    @(negedge clk);
    dividend = W'(5);
    divisor  = W'(9);
    wait_done(1'b1, 0, edges, ov);
    finish_op("b2b_5_9", 5, 9, edges, ov);

    // Divide by zero.
    run_op("d37_0", 37, 0);

    // Reset in the middle of CALC, with start held while reset is low.
    launch(200, 13);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    dividend = W'(200);
    divisor  = W'(13);
    start    = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_accept_busy", busy, 1);
    start = 1'b0;
    wait_done(1'b1, 1, edges, ov);
    finish_op("d200_13", 200, 13, edges, ov);

    // Operand changes and a start pulse during CALC are ignored.
    launch(100, 7);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    dividend = W'(3);
    divisor  = W'(1);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'(200);
    wait_done(1'b1, 2, edges, ov);
    finish_op("ign_100_7", 100, 7, edges, ov);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
